// File: rtl/tlb_walk_arbiter.sv
// -----------------------------------------------------------------------------
// tlb_walk_arbiter
//
// Purpose:
//   Shares the MMU's single page-table walker between the I-TLB and the D-TLB.
//   Miss requests from both TLBs are arbitrated and one walk is issued at a
//   time. The walker response is then steered into the requesting TLB's
//   replace port. TLB flushes requested on `clear` are sequenced so that a
//   flush never races an in-flight fill.
//
// Configuration:
//   DSIDE_PRIO        1 = D-side always wins simultaneous misses,
//                     0 = round-robin between the two sides.
//   VA_W              width of the virtual-address ports.
//   TLB_WALK_STATS_EN (macro) when defined, builds the four 64-bit statistics
//                     counters. When undefined, the counter outputs are tied
//                     to zero and no counter flops exist.
//
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   active                           translation enabled (gates new grants)
//   clear                            single-cycle flush request
//   i_miss_req/i_miss_va             I-TLB miss (level) and its VA
//   i_miss_ack/i_fault               I-side resolve pulse and fault qualifier
//   d_miss_req/d_miss_va             D-TLB miss (level) and its VA
//   d_miss_ack/d_fault               D-side resolve pulse and fault qualifier
//   walk_req/walk_va/walk_iside      walk start pulse, latched VA, side
//   walk_rsp_valid/walk_fault/walk_rsp  walker completion, fault, result
//   itlb_replace/dtlb_replace        replace strobes
//   replace_va/replace_rsp           replace VA and registered walk result
//   itlb_clear/dtlb_clear            flush strobes
//   busy                             FSM is not idle
//   walks_i/walks_d/walk_faults/walk_cycles  statistics counters
//
// Handshake:
//   *_miss_req is a level held by the TLB until the matching one-cycle
//   *_miss_ack. *_fault is only meaningful while *_miss_ack is high.
//   walk_req is a one-cycle start pulse; the walker answers with a one-cycle
//   walk_rsp_valid, qualified by walk_fault. Responses outside WALK are ignored.
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------

package tlb_walk_arbiter_pkg;
    typedef struct packed {
        logic [43:0] ppn;
        logic [1:0]  level;
        logic [7:0]  perm;
    } page_walk_rsp_t;
endpackage

module tlb_walk_arbiter
    import tlb_walk_arbiter_pkg::*;
#(
    parameter int unsigned DSIDE_PRIO = 0,
    parameter int unsigned VA_W       = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            active,
    input  logic            clear,
    input  logic            i_miss_req,
    input  logic [VA_W-1:0] i_miss_va,
    output logic            i_miss_ack,
    output logic            i_fault,
    input  logic            d_miss_req,
    input  logic [VA_W-1:0] d_miss_va,
    output logic            d_miss_ack,
    output logic            d_fault,
    output logic            walk_req,
    output logic [VA_W-1:0] walk_va,
    output logic            walk_iside,
    input  logic            walk_rsp_valid,
    input  logic            walk_fault,
    input  page_walk_rsp_t  walk_rsp,
    output logic            itlb_replace,
    output logic            dtlb_replace,
    output logic [VA_W-1:0] replace_va,
    output page_walk_rsp_t  replace_rsp,
    output logic            itlb_clear,
    output logic            dtlb_clear,
    output logic            busy,
    output logic [63:0]     walks_i,
    output logic [63:0]     walks_d,
    output logic [63:0]     walk_faults,
    output logic [63:0]     walk_cycles
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WALK  = 3'd1,
        S_FILL  = 3'd2,
        S_ACK   = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    // State and registered outputs
    state_t          r_state;
    logic            r_walk_req;
    logic [VA_W-1:0] r_walk_va;
    logic            r_iside;
    logic            r_last_iside;
    logic            r_clear_pend;
    logic [1:0]      r_mask;          // bit0 = I-side masked, bit1 = D-side masked
    logic            r_itlb_replace;
    logic            r_dtlb_replace;
    logic [VA_W-1:0] r_replace_va;
    page_walk_rsp_t  r_replace_rsp;
    logic            r_i_ack;
    logic            r_i_fault;
    logic            r_d_ack;
    logic            r_d_fault;
    logic            r_clr;
    logic            r_busy;

    // Next-state / next-output combinational values
    state_t          w_state_nxt;
    logic            w_req_i;
    logic            w_req_d;
    logic            w_grant;
    logic            w_grant_iside;
    logic            w_take_rsp;
    logic            w_irep_nxt;
    logic            w_drep_nxt;
    logic            w_i_ack_nxt;
    logic            w_i_fault_nxt;
    logic            w_d_ack_nxt;
    logic            w_d_fault_nxt;
    logic            w_clr_nxt;
    logic            w_clear_pend_nxt;
    logic [1:0]      w_mask_nxt;

    // The mask hides the side just acked for one IDLE evaluation, giving the
    // requester a cycle to drop its level request before it could be re-granted.
    assign w_req_i = i_miss_req & ~r_mask[0];
    assign w_req_d = d_miss_req & ~r_mask[1];

    always_comb begin
        w_state_nxt      = r_state;
        w_grant          = 1'b0;
        w_grant_iside    = 1'b0;
        w_take_rsp       = 1'b0;
        w_irep_nxt       = 1'b0;
        w_drep_nxt       = 1'b0;
        w_i_ack_nxt      = 1'b0;
        w_i_fault_nxt    = 1'b0;
        w_d_ack_nxt      = 1'b0;
        w_d_fault_nxt    = 1'b0;
        w_clr_nxt        = 1'b0;
        w_clear_pend_nxt = r_clear_pend;
        w_mask_nxt       = 2'b00;

        case (r_state)
            S_IDLE: begin
                if (clear || r_clear_pend) begin
                    w_state_nxt = S_FLUSH;
                    w_clr_nxt   = 1'b1;
                end else if (active && (w_req_i || w_req_d)) begin
                    w_grant = 1'b1;
                    if (w_req_i && w_req_d) begin
                        // Round-robin: serve the side that did not go last.
                        w_grant_iside = (DSIDE_PRIO != 0) ? 1'b0 : ~r_last_iside;
                    end else begin
                        w_grant_iside = w_req_i;
                    end
                    w_state_nxt = S_WALK;
                end
            end

            S_WALK: begin
                if (clear) begin
                    w_clear_pend_nxt = 1'b1;
                end
                if (walk_rsp_valid) begin
                    if (clear || r_clear_pend) begin
                        // Translation is stale after the flush: drop it and ack
                        // without fault so the requester retries.
                        w_state_nxt = S_ACK;
                        w_i_ack_nxt = r_iside;
                        w_d_ack_nxt = ~r_iside;
                    end else if (walk_fault) begin
                        w_state_nxt   = S_ACK;
                        w_i_ack_nxt   = r_iside;
                        w_d_ack_nxt   = ~r_iside;
                        w_i_fault_nxt = r_iside;
                        w_d_fault_nxt = ~r_iside;
                    end else begin
                        w_state_nxt = S_FILL;
                        w_take_rsp  = 1'b1;
                        w_irep_nxt  = r_iside;
                        w_drep_nxt  = ~r_iside;
                    end
                end
            end

            S_FILL: begin
                if (clear) begin
                    w_clear_pend_nxt = 1'b1;
                end
                w_state_nxt = S_ACK;
                w_i_ack_nxt = r_iside;
                w_d_ack_nxt = ~r_iside;
            end

            S_ACK: begin
                if (clear) begin
                    w_clear_pend_nxt = 1'b1;
                end
                w_state_nxt = S_IDLE;
                w_mask_nxt  = r_iside ? 2'b01 : 2'b10;
            end

            S_FLUSH: begin
                // A clear arriving here is covered by this same flush.
                w_clear_pend_nxt = 1'b0;
                w_state_nxt      = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_walk_req     <= 1'b0;
            r_walk_va      <= '0;
            r_iside        <= 1'b0;
            r_last_iside   <= 1'b0;
            r_clear_pend   <= 1'b0;
            r_mask         <= 2'b00;
            r_itlb_replace <= 1'b0;
            r_dtlb_replace <= 1'b0;
            r_replace_va   <= '0;
            r_replace_rsp  <= '0;
            r_i_ack        <= 1'b0;
            r_i_fault      <= 1'b0;
            r_d_ack        <= 1'b0;
            r_d_fault      <= 1'b0;
            r_clr          <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_walk_req     <= w_grant;
            r_clear_pend   <= w_clear_pend_nxt;
            r_mask         <= w_mask_nxt;
            r_itlb_replace <= w_irep_nxt;
            r_dtlb_replace <= w_drep_nxt;
            r_i_ack        <= w_i_ack_nxt;
            r_i_fault      <= w_i_fault_nxt;
            r_d_ack        <= w_d_ack_nxt;
            r_d_fault      <= w_d_fault_nxt;
            r_clr          <= w_clr_nxt;
            r_busy         <= (w_state_nxt != S_IDLE);
            if (w_grant) begin
                r_walk_va    <= w_grant_iside ? i_miss_va : d_miss_va;
                r_iside      <= w_grant_iside;
                r_last_iside <= w_grant_iside;
            end
            if (w_take_rsp) begin
                r_replace_rsp <= walk_rsp;
                r_replace_va  <= r_walk_va;
            end
        end
    end

    assign walk_req     = r_walk_req;
    assign walk_va      = r_walk_va;
    assign walk_iside   = r_iside;
    assign itlb_replace = r_itlb_replace;
    assign dtlb_replace = r_dtlb_replace;
    assign replace_va   = r_replace_va;
    assign replace_rsp  = r_replace_rsp;
    assign i_miss_ack   = r_i_ack;
    assign i_fault      = r_i_fault;
    assign d_miss_ack   = r_d_ack;
    assign d_fault      = r_d_fault;
    assign itlb_clear   = r_clr;
    assign dtlb_clear   = r_clr;
    assign busy         = r_busy;

`ifdef TLB_WALK_STATS_EN
    logic [63:0] r_walks_i;
    logic [63:0] r_walks_d;
    logic [63:0] r_walk_faults;
    logic [63:0] r_walk_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_walks_i     <= '0;
            r_walks_d     <= '0;
            r_walk_faults <= '0;
            r_walk_cycles <= '0;
        end else begin
            if (w_grant && w_grant_iside) begin
                r_walks_i <= r_walks_i + 64'd1;
            end
            if (w_grant && !w_grant_iside) begin
                r_walks_d <= r_walks_d + 64'd1;
            end
            if ((r_state == S_WALK) && walk_rsp_valid && walk_fault) begin
                r_walk_faults <= r_walk_faults + 64'd1;
            end
            if (r_state == S_WALK) begin
                r_walk_cycles <= r_walk_cycles + 64'd1;
            end
        end
    end

    assign walks_i     = r_walks_i;
    assign walks_d     = r_walks_d;
    assign walk_faults = r_walk_faults;
    assign walk_cycles = r_walk_cycles;
`else
    assign walks_i     = 64'd0;
    assign walks_d     = 64'd0;
    assign walk_faults = 64'd0;
    assign walk_cycles = 64'd0;
`endif

endmodule
